// File: rtl/cpu_boot_pkg.sv
// cpu_boot_pkg: command codes, loader states and default memory depths for the boot loader
package cpu_boot_pkg;

    localparam logic [7:0] CMD_IMEM = 8'hA1;
    localparam logic [7:0] CMD_DMEM = 8'hD2;
    localparam logic [7:0] CMD_GO   = 8'h5A;

    localparam int IMEM_DEPTH_DEF = 256;
    localparam int DMEM_DEPTH_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_IMEM,
        S_DMEM,
        S_RUN
    } state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// boot_word_assembler: gathers four little-endian bytes into a 32-bit instruction word
module boot_word_assembler
    import cpu_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  lane_q;
    logic [23:0] shift_q;

    // The fourth byte is merged combinationally so the word is ready on the cycle it arrives
    assign word_o      = {byte_i, shift_q};
    assign word_done_o = accept_i & (lane_q == 2'd3);

    // Lane counter and byte shift register; clear drops any partially gathered word
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
        end else if (accept_i) begin
            lane_q  <= lane_q + 2'd1;
            shift_q <= {byte_i, shift_q[23:8]};
        end
    end

endmodule

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader: decodes a byte-stream of load commands into IMEM/DMEM writes, then starts the CPU
module cpu_boot_loader
    import cpu_boot_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    localparam int IA = $clog2(IMEM_DEPTH),
    localparam int DA = $clog2(DMEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          imem_we_o,
    output logic [IA-1:0] imem_addr_o,
    output logic [31:0]   imem_data_o,
    output logic          dmem_we_o,
    output logic [DA-1:0] dmem_addr_o,
    output logic [7:0]    dmem_data_o,
    output logic          start_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam int AW = (IA > DA) ? IA : DA;

    state_t        state_q;
    logic          mode_imem_q;
    logic [AW-1:0] addr_q;
    logic [8:0]    cnt_q;
    logic          imem_we_q, dmem_we_q, start_q, err_q;
    logic [IA-1:0] imem_addr_q;
    logic [31:0]   imem_data_q;
    logic [DA-1:0] dmem_addr_q;
    logic [7:0]    dmem_data_q;
    logic          fire, word_done;
    logic [31:0]   word;

    assign in_ready_o  = (state_q != S_RUN);
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_RUN);
    assign fire        = in_valid_i & in_ready_o;
    assign imem_we_o   = imem_we_q;
    assign imem_addr_o = imem_addr_q;
    assign imem_data_o = imem_data_q;
    assign dmem_we_o   = dmem_we_q;
    assign dmem_addr_o = dmem_addr_q;
    assign dmem_data_o = dmem_data_q;
    assign start_o     = start_q;
    assign err_o       = err_q;

    boot_word_assembler u_asm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (state_q != S_IMEM),
        .accept_i    (fire && (state_q == S_IMEM)),
        .byte_i      (in_data_i),
        .word_o      (word),
        .word_done_o (word_done)
    );

    // Frame decoder: command, address, count, payload; write strobes are one-cycle pulses
    always_ff @(posedge clk_i) begin
        imem_we_q <= 1'b0;
        dmem_we_q <= 1'b0;
        if (rst_i) begin
            state_q     <= S_IDLE;
            mode_imem_q <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= 9'd0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= 32'd0;
            dmem_addr_q <= '0;
            dmem_data_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: if (fire) begin
                    if (in_data_i == CMD_IMEM || in_data_i == CMD_DMEM) begin
                        mode_imem_q <= (in_data_i == CMD_IMEM);
                        state_q     <= S_ADDR;
                    end else if (in_data_i == CMD_GO) begin
                        start_q <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                S_ADDR: if (fire) begin
                    addr_q  <= AW'(in_data_i);
                    state_q <= S_CNT;
                end
                S_CNT: if (fire) begin
                    cnt_q   <= (in_data_i == 8'd0) ? 9'd256 : {1'b0, in_data_i};
                    state_q <= mode_imem_q ? S_IMEM : S_DMEM;
                end
                S_IMEM: if (word_done) begin
                    imem_we_q   <= 1'b1;
                    imem_addr_q <= addr_q[IA-1:0];
                    imem_data_q <= word;
                    addr_q      <= addr_q + AW'(1);
                    cnt_q       <= cnt_q - 9'd1;
                    state_q     <= (cnt_q == 9'd1) ? S_IDLE : S_IMEM;
                end
                S_DMEM: if (fire) begin
                    dmem_we_q   <= 1'b1;
                    dmem_addr_q <= addr_q[DA-1:0];
                    dmem_data_q <= in_data_i;
                    addr_q      <= addr_q + AW'(1);
                    cnt_q       <= cnt_q - 9'd1;
                    state_q     <= (cnt_q == 9'd1) ? S_IDLE : S_DMEM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// tb_cpu_boot_loader: directed frames checked every cycle against a frame-level byte model
module tb_cpu_boot_loader;

    typedef logic [7:0] byte_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic        imem_we_o;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_data_o;
    logic        dmem_we_o;
    logic [4:0]  dmem_addr_o;
    logic [7:0]  dmem_data_o;
    logic        start_o;
    logic        busy_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    cpu_boot_loader dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_o (imem_data_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_addr_o (dmem_addr_o),
        .dmem_data_o (dmem_data_o),
        .start_o     (start_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: the bytes of the frame in progress, interpreted by position within the frame
    byte_t       frame[$];
    bit          model_ok = 1'b0;
    bit          run_m, err_m;
    logic        exp_iwe, exp_dwe;
    logic [7:0]  exp_iaddr, exp_ddata;
    logic [4:0]  exp_daddr;
    logic [31:0] exp_idata;

    always @(posedge clk_i) begin
        int n, p, c, isz, item;
        exp_iwe = 1'b0;
        exp_dwe = 1'b0;
        if (rst_i) begin
            frame.delete();
            run_m = 1'b0;
            err_m = 1'b0;
            exp_iaddr = 8'd0;
            exp_idata = 32'd0;
            exp_daddr = 5'd0;
            exp_ddata = 8'd0;
            model_ok = 1'b1;
        end else if (model_ok && in_valid_i && !run_m) begin
            if (frame.size() == 0) begin
                if (in_data_i == 8'hA1 || in_data_i == 8'hD2) frame.push_back(in_data_i);
                else if (in_data_i == 8'h5A) run_m = 1'b1;
                else err_m = 1'b1;
            end else begin
                frame.push_back(in_data_i);
                n = frame.size();
                if (n > 3) begin
                    p    = n - 4;
                    c    = (frame[2] == 8'd0) ? 256 : int'(frame[2]);
                    isz  = (frame[0] == 8'hA1) ? 4 : 1;
                    item = p / isz;
                    if ((p + 1) % isz == 0) begin
                        if (isz == 4) begin
                            exp_iwe   = 1'b1;
                            exp_iaddr = 8'((int'(frame[1]) + item) % 256);
                            exp_idata = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
                        end else begin
                            exp_dwe   = 1'b1;
                            exp_daddr = 5'((int'(frame[1]) + item) % 32);
                            exp_ddata = frame[n-1];
                        end
                    end
                    if (p + 1 == c * isz) frame.delete();
                end
            end
        end
    end

    // Every cycle after the first reset edge, all outputs must equal the model
    always @(negedge clk_i) begin
        if (model_ok) begin
            check("in_ready", 32'(in_ready_o), 32'(!run_m));
            check("start", 32'(start_o), 32'(run_m));
            check("busy", 32'(busy_o), 32'(frame.size() != 0));
            check("err", 32'(err_o), 32'(err_m));
            check("imem_we", 32'(imem_we_o), 32'(exp_iwe));
            check("imem_addr", 32'(imem_addr_o), 32'(exp_iaddr));
            check("imem_data", imem_data_o, exp_idata);
            check("dmem_we", 32'(dmem_we_o), 32'(exp_dwe));
            check("dmem_addr", 32'(dmem_addr_o), 32'(exp_daddr));
            check("dmem_data", 32'(dmem_data_o), 32'(exp_ddata));
        end
    end

    // Write log used by the hand-computed checks
    int          iw_n = 0;
    logic [7:0]  iq[$];
    logic [31:0] last_idata;
    logic [4:0]  dq[$];
    logic [7:0]  last_ddata;

    always @(negedge clk_i) begin
        if (imem_we_o) begin
            iw_n++;
            iq.push_back(imem_addr_o);
            last_idata = imem_data_o;
        end
        if (dmem_we_o) begin
            dq.push_back(dmem_addr_o);
            last_ddata = dmem_data_o;
        end
    end

    byte_t bq[$];

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send(input byte_t b);
        in_valid_i = 1'b1;
        in_data_i  = b;
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic send_q(input bit gappy);
        foreach (bq[i]) begin
            if (gappy) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid_i = 1'b0;
                    in_data_i  = 8'($urandom);
                    @(negedge clk_i);
                end
            end
            send(bq[i]);
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        in_data_i  = 8'd0;
        repeat (2) @(negedge clk_i);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_imem_addr", 32'(imem_addr_o), 32'd0);
        rst_i = 1'b0;
        idle(1);

        bq = '{8'hA1, 8'h00, 8'h01, 8'h13, 8'h00, 8'h08, 8'h20};
        send_q(1'b0);
        idle(2);
        check("t1_count", 32'(iw_n), 32'd1);
        check("t1_addr", 32'(iq[0]), 32'd0);
        check("t1_data", last_idata, 32'h20080013);

        bq = '{8'hD2, 8'h00, 8'h01, 8'h05};
        send_q(1'b0);
        idle(2);
        check("t2_count", 32'(dq.size()), 32'd1);
        check("t2_addr", 32'(dq[0]), 32'd0);
        check("t2_data", 32'(last_ddata), 32'h05);
        check("t2_err", 32'(err_o), 32'd0);

        bq = '{8'hA1, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_q(1'b0);
        idle(2);
        check("t3_imem_count", 32'(iw_n), 32'd3);
        check("t3_imem_addr_a", 32'(iq[1]), 32'd255);
        check("t3_imem_addr_b", 32'(iq[2]), 32'd0);
        check("t3_imem_data", last_idata, 32'h88776655);

        dq.delete();
        bq = '{8'hD2, 8'h1F, 8'h00};
        for (int i = 0; i < 256; i++) bq.push_back(8'(i));
        send_q(1'b0);
        idle(2);
        check("t3_dmem_count", 32'(dq.size()), 32'd256);
        check("t3_dmem_first", 32'(dq[0]), 32'd31);
        check("t3_dmem_wrap", 32'(dq[1]), 32'd0);
        check("t3_dmem_last", 32'(dq[255]), 32'd30);
        check("t3_dmem_data", 32'(last_ddata), 32'hFF);

        bq = '{8'hA1, 8'h00, 8'h01, 8'h13, 8'h00, 8'h08, 8'h20};
        send_q(1'b1);
        idle(2);
        check("t4_count", 32'(iw_n), 32'd4);
        check("t4_data", last_idata, 32'h20080013);

        send(8'h33);
        idle(3);
        check("t5_err", 32'(err_o), 32'd1);
        check("t5_no_write", 32'(iw_n), 32'd4);
        bq = '{8'hA1, 8'h10, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_q(1'b0);
        idle(2);
        check("t5_count", 32'(iw_n), 32'd5);
        check("t5_addr", 32'(iq[4]), 32'd16);
        check("t5_data", last_idata, 32'hDEADBEEF);
        check("t5_err_sticky", 32'(err_o), 32'd1);

        send(8'h5A);
        check("t6_start", 32'(start_o), 32'd1);
        check("t6_ready", 32'(in_ready_o), 32'd0);
        send(8'hA1);
        idle(3);
        check("t6_start_hold", 32'(start_o), 32'd1);
        check("t6_busy_run", 32'(busy_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("t6_rst_start", 32'(start_o), 32'd0);
        check("t6_rst_err", 32'(err_o), 32'd0);
        bq = '{8'hA1, 8'h00, 8'h01, 8'h13, 8'h00};
        send_q(1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(3);
        check("t6_no_partial", 32'(iw_n), 32'd5);
        check("t6_idle_busy", 32'(busy_o), 32'd0);
        check("t6_idle_start", 32'(start_o), 32'd0);
        bq = '{8'hA1, 8'h05, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
        send_q(1'b0);
        idle(2);
        check("t6_reload_count", 32'(iw_n), 32'd6);
        check("t6_reload_addr", 32'(iq[5]), 32'd5);
        check("t6_reload_data", last_idata, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
